// File: rtl/cp0_unit_if.sv
// cp0_unit_if: bus bundle between the pipeline and the CP0 register block.
// The pipeline side (master) drives the mtc0/mfc0, exception and eret strobes;
// the CP0 side (slave) returns read data, interrupt request and live register values.
interface cp0_unit_if #(
  parameter int NUM_HW_INT = 6
);
  logic [NUM_HW_INT-1:0] hw_int_i;
  logic                  we_i;
  logic [4:0]            waddr_i;
  logic [31:0]           wdata_i;
  logic [4:0]            raddr_i;
  logic [31:0]           rdata_o;
  logic                  exc_valid_i;
  logic [4:0]            exc_code_i;
  logic [31:0]           exc_pc_i;
  logic                  exc_bd_i;
  logic [31:0]           exc_badvaddr_i;
  logic                  eret_i;
  logic                  int_req_o;
  logic                  timer_int_o;
  logic [31:0]           status_o;
  logic [31:0]           cause_o;
  logic [31:0]           epc_o;

  modport master (
    output hw_int_i, we_i, waddr_i, wdata_i, raddr_i,
    output exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    input  rdata_o, int_req_o, timer_int_o, status_o, cause_o, epc_o
  );

  modport slave (
    input  hw_int_i, we_i, waddr_i, wdata_i, raddr_i,
    input  exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    output rdata_o, int_req_o, timer_int_o, status_o, cause_o, epc_o
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS-style coprocessor 0 subset (BadVAddr, Count, Compare, Status,
// Cause, EPC, PRId, Config) with timer interrupt and exception/eret bookkeeping.
module cp0_unit #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 1,
  parameter int          TIMER_IP7  = 1,
  parameter logic [31:0] PRID_VAL   = 32'h0000_0000,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic       clk,
  input  logic       rst,
  cp0_unit_if.slave  bus
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  logic [31:0] r_count;
  logic        r_div_phase;
  logic [31:0] r_compare;
  logic        r_cmp_written;
  logic        r_timer_pend;
  logic [5:0]  r_hw;
  logic [1:0]  r_ip_sw;
  logic        r_bd;
  logic [4:0]  r_exc_code;
  logic        r_cu0;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic [5:0]  w_hw;
  logic [7:0]  w_ip;
  logic [31:0] w_cause;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;

  assign w_wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
  assign w_wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
  assign w_wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
  assign w_wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
  assign w_wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);

  // Pad the external interrupt lines to the full six IP slots; absent lines read 0.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_hw
      if (gi < NUM_HW_INT) begin : g_used
        assign w_hw[gi] = bus.hw_int_i[gi];
      end else begin : g_unused
        assign w_hw[gi] = 1'b0;
      end
    end
  endgenerate

  // IP7 shares hw line 5 with the timer; IP1:0 are the software interrupts.
  assign w_ip     = {r_hw[5] | (r_timer_pend & (TIMER_IP7 != 0)), r_hw[4:0], r_ip_sw};
  assign w_cause  = {r_bd, 15'b0, w_ip, 1'b0, r_exc_code, 2'b0};
  assign w_status = {3'b0, r_cu0, 12'b0, r_im, 6'b0, r_exl, r_ie};

  // Free-running Count; a write reloads it and restarts the divider phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_div_phase <= 1'b0;
    end else if (w_wr_count) begin
      r_count     <= bus.wdata_i;
      r_div_phase <= 1'b0;
    end else if (COUNT_DIV == 1) begin
      r_count     <= r_count + 32'd1;
    end else begin
      r_div_phase <= ~r_div_phase;
      if (r_div_phase) r_count <= r_count + 32'd1;
    end
  end

  // Compare register and sticky timer pending; writing Compare acknowledges the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_compare     <= '0;
      r_cmp_written <= 1'b0;
      r_timer_pend  <= 1'b0;
    end else if (w_wr_compare) begin
      r_compare     <= bus.wdata_i;
      r_cmp_written <= 1'b1;
      r_timer_pend  <= 1'b0;
    end else if (r_cmp_written && (r_count == r_compare)) begin
      r_timer_pend  <= 1'b1;
    end
  end

  // Cause fields: sampled interrupt lines, software IP bits, exception code and BD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hw       <= '0;
      r_ip_sw    <= '0;
      r_bd       <= 1'b0;
      r_exc_code <= '0;
    end else begin
      r_hw <= w_hw;
      if (w_wr_cause) r_ip_sw <= bus.wdata_i[9:8];
      if (bus.exc_valid_i) begin
        r_exc_code <= bus.exc_code_i;
        if (!r_exl) r_bd <= bus.exc_bd_i;
      end
    end
  end

  // Status fields; EXL is owned by exception first, then eret, then software.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cu0 <= 1'b1;
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
    end else begin
      if (w_wr_status) begin
        r_cu0 <= bus.wdata_i[28];
        r_im  <= bus.wdata_i[15:8];
        r_ie  <= bus.wdata_i[0];
      end
      if (bus.exc_valid_i)  r_exl <= 1'b1;
      else if (bus.eret_i)  r_exl <= 1'b0;
      else if (w_wr_status) r_exl <= bus.wdata_i[1];
    end
  end

  // EPC is captured only on the first exception (EXL clear); a committing exception blocks mtc0 EPC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else if (bus.exc_valid_i) begin
      if (!r_exl) r_epc <= bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
      if ((bus.exc_code_i == 5'd4) || (bus.exc_code_i == 5'd5)) r_badvaddr <= bus.exc_badvaddr_i;
    end else if (w_wr_epc) begin
      r_epc <= bus.wdata_i;
    end
  end

  // mfc0 read mux; reads return register state before any same-cycle write.
  always_comb begin
    w_rdata = '0;
    if (!rst) begin
      case (bus.raddr_i)
        REG_BADVADDR: w_rdata = r_badvaddr;
        REG_COUNT:    w_rdata = r_count;
        REG_COMPARE:  w_rdata = r_compare;
        REG_STATUS:   w_rdata = w_status;
        REG_CAUSE:    w_rdata = w_cause;
        REG_EPC:      w_rdata = r_epc;
        REG_PRID:     w_rdata = PRID_VAL;
        REG_CONFIG:   w_rdata = CONFIG_VAL;
        default:      w_rdata = '0;
      endcase
    end
  end

  assign bus.rdata_o     = w_rdata;
  assign bus.int_req_o   = r_ie & ~r_exl & (|(r_im & w_ip));
  assign bus.timer_int_o = r_timer_pend;
  assign bus.status_o    = w_status;
  assign bus.cause_o     = w_cause;
  assign bus.epc_o       = r_epc;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: scoreboard bench for cp0_unit with a behavioural CP0 model,
// directed scenarios and randomized mtc0/exception/eret traffic.
module tb_cp0_unit;
  localparam logic [31:0] PRID = 32'h0001_9300;
  localparam logic [31:0] CFG  = 32'h0000_8000;

  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  cp0_unit_if #(.NUM_HW_INT(6)) bus ();
  cp0_unit_if #(.NUM_HW_INT(2)) bus2 ();

  cp0_unit #(.NUM_HW_INT(6), .COUNT_DIV(1), .TIMER_IP7(1), .PRID_VAL(PRID), .CONFIG_VAL(CFG))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  cp0_unit #(.NUM_HW_INT(2), .COUNT_DIV(2), .TIMER_IP7(0))
    u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  raddr;
    logic [31:0] rdata, status, cause, epc;
    logic        timer, intreq;
  } exp_t;
  exp_t sb_q[$];

  // stimulus variables
  logic        t_rst = 1'b1, t_we = 1'b0, t_exc = 1'b0, t_bd = 1'b0, t_eret = 1'b0;
  logic [4:0]  t_waddr = '0, t_raddr = '0, t_code = '0;
  logic [31:0] t_wdata = '0, t_pc = '0, t_badv = '0;
  logic [5:0]  t_hw = '0;

  // reference model state (architectural fields)
  logic [31:0] m_count, m_compare, m_epc, m_badv;
  int          m_ticks;
  logic        m_cmpw, m_pend, m_bd, m_cu0, m_exl, m_ie;
  logic [5:0]  m_hw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic [7:0]  m_im;

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_pend, m_hw[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
  endfunction

  function automatic logic [31:0] m_status();
    return (32'(m_cu0) << 28) | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return CFG;
      default: return 32'h0;
    endcase
  endfunction

  task automatic apply();
    rst                = t_rst;
    bus.we_i           = t_we;
    bus.waddr_i        = t_waddr;
    bus.wdata_i        = t_wdata;
    bus.raddr_i        = t_raddr;
    bus.hw_int_i       = t_hw;
    bus.exc_valid_i    = t_exc;
    bus.exc_code_i     = t_code;
    bus.exc_pc_i       = t_pc;
    bus.exc_bd_i       = t_bd;
    bus.exc_badvaddr_i = t_badv;
    bus.eret_i         = t_eret;
  endtask

  // Advance the model by one clock using the applied inputs, queue the expectation, wait for the edge.
  task automatic commit();
    exp_t e;
    logic exl_old;
    if (t_rst) begin
      m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0; m_ticks = 0;
      m_cmpw = 0; m_pend = 0; m_bd = 0; m_cu0 = 1; m_exl = 0; m_ie = 0;
      m_hw = 0; m_ipsw = 0; m_code = 0; m_im = 0;
    end else begin
      if (t_we && t_waddr == 5'd11) begin
        m_compare = t_wdata; m_cmpw = 1; m_pend = 0;
      end else if (m_cmpw && m_count == m_compare) begin
        m_pend = 1;
      end
      if (t_we && t_waddr == 5'd9) begin
        m_count = t_wdata; m_ticks = 0;
      end else begin
        m_ticks++;
        m_count = m_count + 1;
      end
      m_hw = t_hw;
      if (t_we && t_waddr == 5'd13) m_ipsw = t_wdata[9:8];
      exl_old = m_exl;
      if (t_we && t_waddr == 5'd12) begin
        m_cu0 = t_wdata[28]; m_im = t_wdata[15:8]; m_ie = t_wdata[0];
      end
      if (t_exc) begin
        m_code = t_code;
        if (!exl_old) begin
          m_epc = t_bd ? t_pc - 32'd4 : t_pc;
          m_bd  = t_bd;
        end
        if (t_code == 5'd4 || t_code == 5'd5) m_badv = t_badv;
        m_exl = 1;
      end else begin
        if (t_eret) m_exl = 0;
        else if (t_we && t_waddr == 5'd12) m_exl = t_wdata[1];
        if (t_we && t_waddr == 5'd14) m_epc = t_wdata;
      end
    end
    e.raddr  = t_raddr;
    e.rdata  = t_rst ? 32'h0 : m_read(t_raddr);
    e.status = m_status();
    e.cause  = m_cause();
    e.epc    = m_epc;
    e.timer  = m_pend;
    e.intreq = m_ie && !m_exl && ((m_im & m_ip()) != 8'h0);
    sb_q.push_back(e);
    t_we = 0; t_exc = 0; t_eret = 0; t_bd = 0;
    @(negedge clk);
  endtask

  task automatic tick();
    apply();
    commit();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.raddr_i = a;
    #1;
    d = bus.rdata_o;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    t_we = 1; t_waddr = a; t_wdata = d;
  endtask

  task automatic do_reset();
    t_rst = 1; tick(); tick(); t_rst = 0;
  endtask

  // Monitor: pops one expectation per clock and compares every observable output.
  int txn = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d raddr=%0d rdata=%h status=%h cause=%h epc=%h tmr=%0b irq=%0b",
                 txn, e.raddr, bus.rdata_o, bus.status_o, bus.cause_o, bus.epc_o,
                 bus.timer_int_o, bus.int_req_o);
        chk("sb_rdata",  bus.rdata_o,        e.rdata);
        chk("sb_status", bus.status_o,       e.status);
        chk("sb_cause",  bus.cause_o,        e.cause);
        chk("sb_epc",    bus.epc_o,          e.epc);
        chk("sb_timer",  32'(bus.timer_int_o), 32'(e.timer));
        chk("sb_intreq", 32'(bus.int_req_o),   32'(e.intreq));
      end
    end
  end

  logic [4:0] addr_tab [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
  logic [4:0] code_tab [5] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10};

  initial begin
    logic [31:0] d;
    // second instance: COUNT_DIV=2, two interrupt lines, timer not on IP7
    rst2 = 1;
    bus2.hw_int_i = 2'b11; bus2.we_i = 0; bus2.waddr_i = 0; bus2.wdata_i = 0; bus2.raddr_i = 5'd9;
    bus2.exc_valid_i = 0; bus2.exc_code_i = 0; bus2.exc_pc_i = 0; bus2.exc_bd_i = 0;
    bus2.exc_badvaddr_i = 0; bus2.eret_i = 0;
    t_rst = 1; t_raddr = 5'd12;
    tick(); tick();
    chk("rst_rdata_zero", bus.rdata_o, 32'h0);
    chk("rst_status", bus.status_o, 32'h1000_0000);
    chk("rst_cause", bus.cause_o, 32'h0);
    chk("rst_epc", bus.epc_o, 32'h0);
    rst2 = 0;
    bus2.we_i = 1; bus2.waddr_i = 5'd9; bus2.wdata_i = 32'hFFFF_FFFE;
    tick();
    bus2.we_i = 0;
    chk("div2_load", bus2.rdata_o, 32'hFFFF_FFFE);
    chk("div2_hw_lines", bus2.cause_o, 32'h0000_0C00);
    tick(); tick();
    chk("div2_after2", bus2.rdata_o, 32'hFFFF_FFFF);
    tick(); tick();
    chk("div2_wrap_after4", bus2.rdata_o, 32'h0);

    // Timer: Compare=5 then Count=0; pending appears when Count reads 6
    do_reset();
    t_raddr = 5'd9;
    tick(); tick();
    chk("timer_no_cmp_written", 32'(bus.timer_int_o), 32'h0);
    wr(5'd11, 32'd5); tick();
    wr(5'd9, 32'd0);  tick();
    chk("count_loaded", bus.rdata_o, 32'd0);
    repeat (5) tick();
    chk("count_at5", bus.rdata_o, 32'd5);
    chk("timer_at5", 32'(bus.timer_int_o), 32'h0);
    tick();
    chk("count_at6", bus.rdata_o, 32'd6);
    chk("timer_at6", 32'(bus.timer_int_o), 32'h1);
    chk("timer_ip7", bus.cause_o & 32'h0000_8000, 32'h0000_8000);
    wr(5'd11, 32'd100); tick();
    chk("timer_cleared", 32'(bus.timer_int_o), 32'h0);

    // Interrupt request then masked by exception level
    do_reset();
    t_hw = 6'b000001;
    wr(5'd12, 32'h0000_0401); tick();
    chk("cause_ip2", bus.cause_o & 32'h0000_0400, 32'h0000_0400);
    chk("intreq_on", 32'(bus.int_req_o), 32'h1);
    t_exc = 1; t_code = 5'd0; t_pc = 32'h8000_0040; tick();
    chk("exl_set", bus.status_o & 32'h2, 32'h2);
    chk("intreq_masked", 32'(bus.int_req_o), 32'h0);
    t_hw = 0;

    // Delay-slot exception, then nested exception keeps EPC/BD
    do_reset();
    t_exc = 1; t_code = 5'd4; t_pc = 32'h8000_0104; t_bd = 1; t_badv = 32'h3; tick();
    chk("epc_bd", bus.epc_o, 32'h8000_0100);
    chk("cause_bd", bus.cause_o & 32'h8000_0000, 32'h8000_0000);
    rd(5'd8, d);
    chk("badvaddr", d, 32'h3);
    t_exc = 1; t_code = 5'd10; t_pc = 32'h9000_0000; t_bd = 0; tick();
    chk("epc_nested", bus.epc_o, 32'h8000_0100);
    chk("exccode_nested", (bus.cause_o >> 2) & 32'h1F, 32'd10);
    chk("bd_nested", bus.cause_o & 32'h8000_0000, 32'h8000_0000);

    // Exception beats same-cycle mtc0 EPC; eret clears EXL; no forwarding of writes
    do_reset();
    t_exc = 1; t_code = 5'd8; t_pc = 32'h8000_0200; wr(5'd14, 32'h1234); tick();
    chk("epc_exc_wins", bus.epc_o, 32'h8000_0200);
    t_eret = 1; tick();
    chk("eret_exl", bus.status_o & 32'h2, 32'h0);
    wr(5'd12, 32'h0000_FF01); t_raddr = 5'd12; apply(); #1;
    chk("no_forward", bus.rdata_o, 32'h1000_0000);
    commit();
    chk("status_written", bus.rdata_o, 32'h0000_FF01);
    rd(5'd15, d); chk("prid", d, PRID);
    rd(5'd16, d); chk("config", d, CFG);
    rd(5'd3, d);  chk("unimpl_read", d, 32'h0);

    // Cause write mask, then reset mid-count
    do_reset();
    wr(5'd13, 32'hFFFF_FFFF); tick();
    chk("cause_mask", bus.cause_o, 32'h0000_0300);
    wr(5'd12, 32'h0000_0303); tick();
    repeat (3) tick();
    t_rst = 1; t_raddr = 5'd9; tick();
    chk("midrst_rdata", bus.rdata_o, 32'h0);
    chk("midrst_status", bus.status_o, 32'h1000_0000);
    chk("midrst_cause", bus.cause_o, 32'h0);
    chk("midrst_irq", 32'(bus.int_req_o), 32'h0);
    t_rst = 0; tick();
    chk("count_after_rst", bus.rdata_o, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      t_rst   = ($urandom_range(0, 99) < 2);
      t_we    = ($urandom_range(0, 2) == 0);
      t_waddr = addr_tab[$urandom_range(0, 8)];
      t_wdata = $urandom;
      if (t_waddr == 5'd11 && $urandom_range(0, 1) == 1) t_wdata = m_count + 32'($urandom_range(0, 8));
      if (t_waddr == 5'd9 && $urandom_range(0, 3) == 0) t_wdata = 32'hFFFF_FFF8;
      t_raddr = addr_tab[$urandom_range(0, 8)];
      t_hw    = 6'($urandom);
      t_exc   = ($urandom_range(0, 9) == 0);
      t_code  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : code_tab[$urandom_range(0, 4)];
      t_pc    = $urandom;
      t_bd    = 1'($urandom);
      t_badv  = $urandom;
      t_eret  = ($urandom_range(0, 7) == 0);
      if (t_exc && t_we && t_waddr == 5'd14) t_we = 0;
      tick();
    end

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
